// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants and helpers for the Gray/binary converter pipeline
//
// Contents:
//   MODE_G2B / MODE_B2G : per-word conversion selector encoding
//   calc_ch             : bits resolved per stage (ceiling of DSIZE/STAGES)
//   stage_hi / stage_lo : bit range a given stage resolves in Gray-to-binary mode
//                         (stage_hi < 0 means the stage has nothing left to resolve)

package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    function automatic int calc_ch(input int dsize, input int stages);
        return (dsize + stages - 1) / stages;
    endfunction

    function automatic int stage_hi(input int dsize, input int ch, input int idx);
        return dsize - 1 - idx * ch;
    endfunction

    function automatic int stage_lo(input int dsize, input int ch, input int idx);
        int lo;
        lo = dsize - (idx + 1) * ch;
        if (lo < 0) begin
            lo = 0;
        end
        return lo;
    endfunction

endpackage

// File: rtl/gray_bin_stage.sv
// rtl/gray_bin_stage.sv - one register stage of the Gray/binary conversion pipeline
//
// Parameters:
//   DSIZE     : word width
//   CH        : Gray bits resolved per stage
//   STAGE_IDX : position of this stage (0 = first)
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   up_valid/mode/data    : word offered by the previous stage (or the block input)
//   down_ready            : next stage (or the block output) can take this stage's word
//   valid/mode/data       : registered word held by this stage

module gray_bin_stage
    import gray_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int CH        = 4,
    parameter int STAGE_IDX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic             up_mode,
    input  logic [DSIZE-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic             mode,
    output logic [DSIZE-1:0] data
);

    localparam int HI = stage_hi(DSIZE, CH, STAGE_IDX);
    localparam int LO = stage_lo(DSIZE, CH, STAGE_IDX);

    logic             up_ready;
    logic [DSIZE-1:0] nxt_data;
    logic             carry;

    // In G2B mode the word carries already-resolved binary bits above HI and
    // untouched Gray bits below. Walking from the MSB, carry tracks the binary
    // bit just above the current position: outside this stage's slice it is
    // simply the incoming bit (already binary above HI), inside the slice it
    // accumulates the prefix XOR.
    always_comb begin
        nxt_data = up_data;
        carry    = 1'b0;
        if (up_mode == MODE_B2G) begin
            if (STAGE_IDX == 0) begin
                nxt_data = up_data ^ (up_data >> 1);
            end
        end else begin
            for (int i = DSIZE - 1; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    carry       = carry ^ up_data[i];
                    nxt_data[i] = carry;
                end else begin
                    carry = up_data[i];
                end
            end
        end
    end

    // An empty stage always accepts, so bubbles collapse under backpressure.
    assign up_ready = !valid || down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            mode  <= 1'b0;
            data  <= '0;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                mode <= up_mode;
                data <= nxt_data;
            end
        end
    end

endmodule

// File: rtl/gray_bin_pipe.sv
// rtl/gray_bin_pipe.sv - pipelined bidirectional Gray/binary converter with valid/ready
//
// Parameters:
//   DSIZE  : word width (>= 2)
//   STAGES : register stages, equal to the latency in cycles (1..DSIZE)
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready          : input handshake
//   in_mode                    : 0 = Gray->binary, 1 = binary->Gray
//   in_data                    : word to convert
//   out_valid/out_ready        : output handshake
//   out_mode                   : mode the output word was issued with
//   out_data                   : converted word (registered)

module gray_bin_pipe
    import gray_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [DSIZE-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [DSIZE-1:0] out_data
);

    localparam int CH = calc_ch(DSIZE, STAGES);

    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_mode;
    logic [STAGES-1:0] st_down_ready;
    logic [DSIZE-1:0]  st_data [STAGES];

    // The ready seen by stage s is out_ready OR any empty stage downstream of
    // it. Computing it from the valid registers directly (instead of chaining
    // each stage's ready into the next) keeps the path loop-free.
    always_comb begin
        st_down_ready = '0;
        for (int s = 0; s < STAGES; s++) begin
            st_down_ready[s] = out_ready;
            for (int k = s + 1; k < STAGES; k++) begin
                if (!st_valid[k]) begin
                    st_down_ready[s] = 1'b1;
                end
            end
        end
    end

    assign in_ready = !st_valid[0] || st_down_ready[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             u_valid;
        logic             u_mode;
        logic [DSIZE-1:0] u_data;

        if (s == 0) begin : g_first
            assign u_valid = in_valid;
            assign u_mode  = in_mode;
            assign u_data  = in_data;
        end else begin : g_next
            assign u_valid = st_valid[s-1];
            assign u_mode  = st_mode[s-1];
            assign u_data  = st_data[s-1];
        end

        gray_bin_stage #(
            .DSIZE     (DSIZE),
            .CH        (CH),
            .STAGE_IDX (s)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (u_valid),
            .up_mode    (u_mode),
            .up_data    (u_data),
            .down_ready (st_down_ready[s]),
            .valid      (st_valid[s]),
            .mode       (st_mode[s]),
            .data       (st_data[s])
        );
    end

    assign out_valid = st_valid[STAGES-1];
    assign out_mode  = st_mode[STAGES-1];
    assign out_data  = st_data[STAGES-1];

endmodule
